// File: rtl/rca_config_bank.sv
// Double-buffered configuration store for NUM_RCAS accelerators: beats fill a per-RCA
// shadow context, which is committed atomically to the active context once the RCA is idle.
// Optional shadow readback port is enabled by defining RCA_CFG_READBACK_EN.
module rca_config_bank #(
  parameter int NUM_RCAS    = 4,
  parameter int NUM_ENTRIES = 24,
  parameter int FIELD_W     = 5,
  parameter int RCA_W       = $clog2(NUM_RCAS),
  parameter int ADDR_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [RCA_W-1:0]               cfg_rca,
  input  logic [ADDR_W-1:0]              cfg_addr,
  input  logic [FIELD_W-1:0]             cfg_data,
  input  logic                           cfg_last,
  input  logic [NUM_RCAS-1:0]            rca_busy,
  input  logic [RCA_W-1:0]               rd_rca,
  output logic [NUM_ENTRIES*FIELD_W-1:0] rd_cfg,
  output logic [NUM_RCAS-1:0]            cfg_pending,
  output logic                           commit_done,
  output logic [RCA_W-1:0]               commit_rca,
  output logic                           cfg_err
`ifdef RCA_CFG_READBACK_EN
  ,
  input  logic                           rb_valid,
  input  logic [RCA_W-1:0]               rb_rca,
  input  logic [ADDR_W-1:0]              rb_addr,
  output logic [FIELD_W-1:0]             rb_data,
  output logic                           rb_data_valid
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [RCA_W-1:0]   cur_rca;
  logic [FIELD_W-1:0] shadow [NUM_RCAS][NUM_ENTRIES];
  logic [FIELD_W-1:0] active [NUM_RCAS][NUM_ENTRIES];

  logic cfg_rca_ok, rd_rca_ok, cfg_addr_ok;
  logic beat, rca_match, wr_en, beat_err, commit;

  // Index range checks only exist when the parameter does not fill its index width.
  if (NUM_RCAS == (1 << RCA_W)) begin : g_rca_full
    assign cfg_rca_ok = 1'b1;
    assign rd_rca_ok  = 1'b1;
  end else begin : g_rca_part
    assign cfg_rca_ok = (int'(cfg_rca) < NUM_RCAS);
    assign rd_rca_ok  = (int'(rd_rca) < NUM_RCAS);
  end

  if (NUM_ENTRIES == (1 << ADDR_W)) begin : g_addr_full
    assign cfg_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign cfg_addr_ok = (int'(cfg_addr) < NUM_ENTRIES);
  end

  assign cfg_ready = (state != ST_PEND);
  assign beat      = cfg_valid && cfg_ready;
  // In IDLE any valid RCA opens a load; afterwards beats must target the RCA being loaded.
  assign rca_match = (state == ST_IDLE) ? cfg_rca_ok : (cfg_rca == cur_rca);
  assign wr_en     = beat && rca_match && cfg_addr_ok;
  assign beat_err  = beat && !(rca_match && cfg_addr_ok);
  assign commit    = (state == ST_PEND) && !rca_busy[cur_rca];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (beat && rca_match) state_nxt = cfg_last ? ST_PEND : ST_LOAD;
      ST_LOAD: if (beat && rca_match && cfg_last) state_nxt = ST_PEND;
      ST_PEND: if (commit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_rca     <= '0;
      commit_done <= 1'b0;
      commit_rca  <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      commit_done <= commit;
      cfg_err     <= beat_err;
      if (commit) commit_rca <= cur_rca;
      if (beat && rca_match && (state == ST_IDLE)) cur_rca <= cfg_rca;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++)
        for (int unsigned e = 0; e < NUM_ENTRIES; e++)
          shadow[r][e] <= '0;
    end else if (wr_en) begin
      shadow[cfg_rca][cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++)
        for (int unsigned e = 0; e < NUM_ENTRIES; e++)
          active[r][e] <= '0;
    end else if (commit) begin
      for (int unsigned e = 0; e < NUM_ENTRIES; e++)
        active[cur_rca][e] <= shadow[cur_rca][e];
    end
  end

  always_comb begin
    cfg_pending = '0;
    if (state == ST_PEND) cfg_pending[cur_rca] = 1'b1;
  end

  always_comb begin
    rd_cfg = '0;
    if (rd_rca_ok)
      for (int unsigned e = 0; e < NUM_ENTRIES; e++)
        rd_cfg[e*FIELD_W +: FIELD_W] = active[rd_rca][e];
  end

`ifdef RCA_CFG_READBACK_EN
  logic rb_rca_ok, rb_addr_ok;

  if (NUM_RCAS == (1 << RCA_W)) begin : g_rb_rca_full
    assign rb_rca_ok = 1'b1;
  end else begin : g_rb_rca_part
    assign rb_rca_ok = (int'(rb_rca) < NUM_RCAS);
  end

  if (NUM_ENTRIES == (1 << ADDR_W)) begin : g_rb_addr_full
    assign rb_addr_ok = 1'b1;
  end else begin : g_rb_addr_part
    assign rb_addr_ok = (int'(rb_addr) < NUM_ENTRIES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data       <= '0;
      rb_data_valid <= 1'b0;
    end else begin
      rb_data_valid <= rb_valid;
      if (rb_valid) rb_data <= (rb_rca_ok && rb_addr_ok) ? shadow[rb_rca][rb_addr] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_rca_config_bank.sv
// Scoreboard bench for rca_config_bank: beats update a shadow/active model, expected
// commits and error pulses are queued at drive time and matched when the DUT reports them.
module tb_rca_config_bank;

  localparam int NR = 4;
  localparam int NE = 24;
  localparam int FW = 5;
  localparam int RW = 2;
  localparam int AW = 5;
  localparam int CW = NE * FW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready, cfg_last;
  logic [RW-1:0] cfg_rca, rd_rca, commit_rca;
  logic [AW-1:0] cfg_addr;
  logic [FW-1:0] cfg_data;
  logic [NR-1:0] rca_busy, cfg_pending;
  logic [CW-1:0] rd_cfg;
  logic          commit_done, cfg_err;
`ifdef RCA_CFG_READBACK_EN
  logic          rb_valid;
  logic [RW-1:0] rb_rca;
  logic [AW-1:0] rb_addr;
  logic [FW-1:0] rb_data;
  logic          rb_data_valid;
`endif

  rca_config_bank #(.NUM_RCAS(NR), .NUM_ENTRIES(NE), .FIELD_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rca(cfg_rca),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .rca_busy(rca_busy), .rd_rca(rd_rca), .rd_cfg(rd_cfg),
    .cfg_pending(cfg_pending), .commit_done(commit_done),
    .commit_rca(commit_rca), .cfg_err(cfg_err)
`ifdef RCA_CFG_READBACK_EN
    , .rb_valid(rb_valid), .rb_rca(rb_rca), .rb_addr(rb_addr),
    .rb_data(rb_data), .rb_data_valid(rb_data_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            rca;
    logic [CW-1:0] cfg;
    int            cyc;
  } commit_t;

  commit_t       cm_q[$];
  int            err_q[$];
  commit_t       mon_c;
  int            mon_e;
  logic [FW-1:0] m_shadow [NR][NE];
  logic [FW-1:0] m_active [NR][NE];
  int            cyc = 0;
  int            n_commit = 0;
  int            last_commit_cyc = -1;
  int            n_checks = 0;
  int            n_pass = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [CW-1:0] pack_shadow(input int r);
    logic [CW-1:0] v;
    for (int e = 0; e < NE; e++) v[e*FW +: FW] = m_shadow[r][e];
    return v;
  endfunction

  function automatic logic [CW-1:0] pack_active(input int r);
    logic [CW-1:0] v;
    for (int e = 0; e < NE; e++) v[e*FW +: FW] = m_active[r][e];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < NE; e++) begin
        m_shadow[r][e] = '0;
        m_active[r][e] = '0;
      end
  endtask

  // Output side of the scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_err) begin
        if (err_q.size() == 0) check_eq("err_unexpected", cfg_err, 1'b0);
        else begin
          mon_e = err_q.pop_front();
          check_eq("err_cycle", cyc, mon_e);
        end
      end
      if (commit_done) begin
        if (cm_q.size() == 0) check_eq("commit_unexpected", commit_done, 1'b0);
        else begin
          mon_c = cm_q.pop_front();
          check_eq("commit_rca", commit_rca, mon_c.rca);
          if (mon_c.cyc >= 0) check_eq("commit_cycle", cyc, mon_c.cyc);
          check_eq("commit_rd_cfg", rd_cfg, mon_c.cfg);
          for (int e = 0; e < NE; e++) m_active[mon_c.rca][e] = mon_c.cfg[e*FW +: FW];
          n_commit++;
          last_commit_cyc = cyc;
        end
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1 after the beat edge.
  task automatic send_beat(input int r, input int a, input int d, input bit last, input bit err);
    check_eq("cfg_ready", cfg_ready, 1'b1);
    cfg_valid = 1'b1;
    cfg_rca   = RW'(r);
    cfg_addr  = AW'(a);
    cfg_data  = FW'(d);
    cfg_last  = last;
    if (err) err_q.push_back(cyc + 1);
    else if (a < NE) m_shadow[r][a] = FW'(d);
    if (last) cm_q.push_back('{r, pack_shadow(r), rca_busy[r] ? -1 : cyc + 2});
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic wait_commits(input int n, input int budget);
    int i = 0;
    while (n_commit < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq("commit_timeout", n_commit, n);
  endtask

  task automatic check_all_active();
    logic [RW-1:0] save = rd_rca;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      rd_rca = RW'(r);
      #1;
      check_eq($sformatf("active%0d", r), rd_cfg, pack_active(r));
    end
    rd_rca = save;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_rca = '0; cfg_addr = '0; cfg_data = '0;
    cfg_last = 1'b0; rca_busy = '0; rd_rca = '0;
`ifdef RCA_CFG_READBACK_EN
    rb_valid = 1'b0; rb_rca = '0; rb_addr = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check_eq("rst_ready", cfg_ready, 1'b1);
    check_eq("rst_pending", cfg_pending, 4'b0000);
    check_eq("rst_commit_done", commit_done, 1'b0);
    check_eq("rst_commit_rca", commit_rca, 2'd0);
    check_eq("rst_err", cfg_err, 1'b0);
    check_all_active();

    // RCA2 load, then a back-to-back partial reload while commit_done is high.
    rd_rca = 2'd2;
    send_beat(2, 0, 'h03, 0, 0);
    send_beat(2, 1, 'h11, 0, 0);
    send_beat(2, 23, 'h1F, 1, 0);
    check_eq("pend_ready", cfg_ready, 1'b0);
    @(posedge clk); #1;
    check_eq("b2b_done", commit_done, 1'b1);
    send_beat(2, 1, 'h05, 1, 0);
    wait_commits(2, 10);
    check_all_active();

    // Same load stalled by rca_busy[2].
    send_beat(2, 0, 'h03, 0, 0);
    send_beat(2, 1, 'h11, 0, 0);
    rca_busy = 4'b0100;
    send_beat(2, 23, 'h1F, 1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_ready", cfg_ready, 1'b0);
      check_eq("stall_pending", cfg_pending, 4'b0100);
      check_eq("stall_rd_cfg", rd_cfg, pack_active(2));
    end
    @(posedge clk); #1;
    d = cyc;
    rca_busy = '0;
    wait_commits(3, 10);
    check_eq("stall_release_cycle", last_commit_cyc, d + 1);
    check_all_active();

    // Foreign-RCA and out-of-range beats inside a load of RCA1.
    rd_rca = 2'd1;
    send_beat(1, 0, 'h09, 0, 0);
    send_beat(3, 0, 'h07, 0, 1);
    send_beat(1, 24, 'h1E, 0, 1);
    send_beat(1, 2, 'h0C, 1, 0);
    wait_commits(4, 10);
    check_all_active();
    // Out-of-range beat carrying last still commits; RCA3 shadow must still be zero.
    rd_rca = 2'd3;
    send_beat(3, 25, 'h01, 1, 1);
    wait_commits(5, 10);
    check_all_active();

    // Reset while RCA0 is pending.
    rd_rca = 2'd2;
    rca_busy = 4'b0001;
    send_beat(0, 0, 'h01, 0, 0);
    send_beat(0, 4, 'h15, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_pend_pending", cfg_pending, 4'b0001);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    cm_q.delete();
    model_reset();
    check_eq("mid_rst_ready", cfg_ready, 1'b1);
    check_eq("mid_rst_pending", cfg_pending, 4'b0000);
    check_eq("mid_rst_done", commit_done, 1'b0);
    check_eq("mid_rst_rd_cfg", rd_cfg, '0);
    rca_busy = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("no_commit_after_rst", n_commit, 5);
    rd_rca = 2'd0;
    send_beat(0, 0, 'h01, 0, 0);
    send_beat(0, 4, 'h15, 1, 0);
    wait_commits(6, 10);
    check_all_active();

`ifdef RCA_CFG_READBACK_EN
    rd_rca = 2'd1;
    send_beat(1, 5, 'h0A, 0, 0);
    rb_valid = 1'b1; rb_rca = 2'd1; rb_addr = 5'd5;
    @(posedge clk); #1;
    rb_valid = 1'b0;
    check_eq("rb_valid", rb_data_valid, 1'b1);
    check_eq("rb_data", rb_data, 5'h0A);
    check_eq("rb_active_untouched", rd_cfg[5*FW +: FW], m_active[1][5]);
    rb_valid = 1'b1; rb_addr = 5'd30;
    @(posedge clk); #1;
    rb_valid = 1'b0;
    check_eq("rb_oor_valid", rb_data_valid, 1'b1);
    check_eq("rb_oor_data", rb_data, 5'h00);
    @(posedge clk); #1;
    check_eq("rb_valid_drop", rb_data_valid, 1'b0);
    send_beat(1, 6, 'h02, 1, 0);
    wait_commits(7, 10);
    check_all_active();
`endif

    repeat (3) @(posedge clk);
    #1;
    check_eq("commit_queue_empty", cm_q.size(), 0);
    check_eq("err_queue_empty", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rca_config_bank.md
Name: rca_config_bank

Overview:
- Parametrised, double-buffered configuration store for NUM_RCAS reconfigurable accelerators.
- Accepts a stream of configuration writes (valid/ready) into a per-RCA shadow context.
- Commits the shadow context atomically to the active context once the target RCA is idle.
- Sits between the RCA configuration decode path and the RCA grid/IO/result crossbars. Active contexts drive those crossbars directly.

Parameters:
- NUM_RCAS, 4, number of accelerator contexts (>=2).
- NUM_ENTRIES, 24, configuration fields per context (CPU src/dest addrs, grid/IO/result mux selects, packed by software).
- FIELD_W, 5, width of each configuration field.
- RCA_W, $clog2(NUM_RCAS), RCA index width (derived).
- ADDR_W, $clog2(NUM_ENTRIES), field address width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config write beat valid
- cfg_ready  out  1  block can accept a beat
- cfg_rca  in  RCA_W  target RCA of the beat
- cfg_addr  in  ADDR_W  field index
- cfg_data  in  FIELD_W  field value
- cfg_last  in  1  final beat of this load; requests commit
- rca_busy  in  NUM_RCAS  per-RCA in-use flags from issue logic
- rd_rca  in  RCA_W  context select for active readout
- rd_cfg  out  NUM_ENTRIES*FIELD_W  active context of rd_rca, field i at bits [i*FIELD_W +: FIELD_W]
- cfg_pending  out  NUM_RCAS  shadow committed-request outstanding per RCA
- commit_done  out  1  one-cycle pulse when a commit occurs
- commit_rca  out  RCA_W  RCA committed on commit_done
- cfg_err  out  1  one-cycle pulse on a rejected beat

Behaviour:
- Reset (async assert, sync deassert by design upstream):
  - all shadow and active fields 0; FSM in IDLE.
  - cfg_ready=1, cfg_pending=0, commit_done=0, commit_rca=0, cfg_err=0.
  - rd_cfg=0.
- A beat transfers when cfg_valid && cfg_ready at a rising clk edge.
- FSM states:
  - IDLE:
    - cfg_ready=1.
    - An accepted beat writes shadow[cfg_rca][cfg_addr] and latches cur_rca=cfg_rca.
    - Next state: PEND if cfg_last, else LOAD.
  - LOAD:
    - cfg_ready=1.
    - A beat with cfg_rca==cur_rca writes shadow; with cfg_last, next state is PEND.
    - A beat with cfg_rca!=cur_rca is consumed, not written, and pulses cfg_err next cycle. State is unchanged.
  - PEND:
    - cfg_ready=0; cfg_pending[cur_rca]=1.
    - Commit occurs on the first edge where rca_busy[cur_rca]==0. That edge copies all NUM_ENTRIES shadow fields of cur_rca to active in one cycle.
    - Registered commit_done=1 and commit_rca=cur_rca appear the following cycle. cfg_pending clears at the same time. Next state: IDLE.
- Out-of-range beat (cfg_addr>=NUM_ENTRIES):
  - consumed, not written, cfg_err pulses next cycle.
  - cfg_last on such a beat still advances to PEND.
- rd_cfg is combinational from active[rd_rca]. A commit becomes visible on rd_cfg in the cycle after the commit edge.
- Active contexts of other RCAs never change during any load or commit.
- rca_busy toggling while in IDLE/LOAD has no effect.
- Reset mid-load or while PEND discards shadow and active contents (all 0). No commit_done is produced.
- Back-to-back loads:
  - after commit, IDLE accepts a new beat in the same cycle commit_done is high.
  - Shadow retains prior values, so partial reloads are legal.
- Latency:
  - beat to shadow: 1 edge.
  - cfg_last beat to commit_done: 2 cycles minimum (accept edge -> PEND, commit edge -> pulse). Extended by rca_busy stall.

Optional Feature:
- Macro RCA_CFG_READBACK_EN.
- When defined, adds ports:
  - rb_valid in 1
  - rb_rca in RCA_W
  - rb_addr in ADDR_W
  - rb_data out FIELD_W
  - rb_data_valid out 1
- Readback behaviour: rb_data is shadow[rb_rca][rb_addr], registered. rb_data_valid pulses 1 cycle after rb_valid.
- Out-of-range rb_addr returns 0 with rb_data_valid=1.
- Both readback outputs reset to 0.
- When undefined, those ports and the readback registers do not exist. All other behaviour is identical.

Test Plan:
- Reset release, rd_rca=0..3 -> rd_cfg=0, cfg_ready=1, cfg_pending=0.
- Load RCA2: addr0=5'h03, addr1=5'h11, addr23=5'h1F with last; rca_busy=0 -> commit_done pulse 2 cycles after last beat, commit_rca=2. rd_rca=2 shows field0=3, field1=0x11, field23=0x1F; RCA0/1/3 remain 0.
- Same load with rca_busy[2]=1 for 10 cycles -> cfg_ready=0 and cfg_pending[2]=1 for the stall. rd_cfg of RCA2 unchanged until busy drops. commit_done one cycle after the busy-drop edge.
- During LOAD to RCA1, beat with cfg_rca=3, addr0=7 -> cfg_err pulse, shadow/active of RCA3 unchanged. Also beat with addr=24 -> cfg_err, no write.
- Assert rst_n=0 while PEND for RCA0 -> outputs return to reset values immediately, no commit_done. Subsequent load of RCA0 commits normally.
- With RCA_CFG_READBACK_EN: write RCA1 addr5=0x0A (no last), readback rca1/addr5 -> rb_data=0x0A one cycle later while active field5 still 0.
